// File: rtl/wimax_pkg.sv
// Constants and shared enums for the 192-bit block interleaver.
// The bank encoding is shared with the read controller.
package wimax_pkg;

    localparam int NCBPS  = 192;
    localparam int D      = 16;
    localparam int ROWS   = NCBPS / D;
    localparam int ADDR_W = 8;
    localparam int ROW_W  = $clog2(D);
    localparam int COL_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        WRITING,
        STALLED
    } WriteControlState_t;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_t;

endpackage

// File: rtl/interleave_addr_gen.sv
// Incremental permuted-address generator: addr = ROWS*(k mod D) + floor(k/D),
// produced without a multiplier by stepping ROWS down a column.
module interleave_addr_gen
    import wimax_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              advance,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last = (row_q == ROW_W'(D - 1)) && (col_q == COL_W'(ROWS - 1));
    assign addr = addr_q;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        addr_d = addr_q;
        if (clear || (advance && last)) begin
            row_d  = '0;
            col_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            if (row_q == ROW_W'(D - 1)) begin
                // end of a column: jump back to the top of the next one
                row_d  = '0;
                col_d  = col_q + COL_W'(1);
                addr_d = ADDR_W'(col_q) + ADDR_W'(1);
            end else begin
                row_d  = row_q + ROW_W'(1);
                addr_d = addr_q + ADDR_W'(ROWS);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/interleaver_write_control.sv
// Write side of the ping-pong interleaver RAM: permuted bank writes,
// bank completion reporting and back-pressure when both banks hold unread data.
module interleaver_write_control
    import wimax_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              data_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              block_consumed,
    output logic              wren,
    output logic [ADDR_W:0]   wraddress,
    output logic              wrdata,
    output logic              valid_out,
    output logic              out_bank
);

    WriteControlState_t state_q, state_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic               wren_q, wren_d;
    logic [ADDR_W:0]    wraddress_q, wraddress_d;
    logic               wrdata_q, wrdata_d;
    logic               done_q, done_d;
    logic               done_bank_q, done_bank_d;
    logic               valid_out_q, valid_out_d;
    logic               out_bank_q, out_bank_d;

    logic              accept;
    logic              complete;
    logic [ADDR_W-1:0] addr;
    logic              last;

    assign ready_in = ~full_q[wr_bank_q];
    assign accept   = valid_in & ready_in;
    assign complete = accept & last;

    interleave_addr_gen u_addr_gen (
        .clk     (clk),
        .resetN  (resetN),
        .advance (accept),
        .clear   (1'b0),
        .addr    (addr),
        .last    (last)
    );

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        state_d   = state_q;

        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        // a consume with nothing full is a reader glitch; ignore it
        if (block_consumed && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        case (state_q)
            IDLE:    if (accept) state_d = WRITING;
            WRITING: if (complete && full_d[wr_bank_d]) state_d = STALLED;
            STALLED: if (!full_d[wr_bank_q]) state_d = WRITING;
            default: state_d = IDLE;
        endcase

        wren_d      = accept;
        wraddress_d = accept ? {wr_bank_q, addr} : wraddress_q;
        wrdata_d    = accept ? data_in : wrdata_q;
        // valid_out trails the final RAM write by one cycle
        done_d      = complete;
        done_bank_d = complete ? wr_bank_q : done_bank_q;
        valid_out_d = done_q;
        out_bank_d  = done_q ? done_bank_q : out_bank_q;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            full_q      <= 2'b00;
            wr_bank_q   <= BANK_A;
            rd_bank_q   <= BANK_A;
            wren_q      <= 1'b0;
            wraddress_q <= '0;
            wrdata_q    <= 1'b0;
            done_q      <= 1'b0;
            done_bank_q <= BANK_A;
            valid_out_q <= 1'b0;
            out_bank_q  <= BANK_A;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wren_q      <= wren_d;
            wraddress_q <= wraddress_d;
            wrdata_q    <= wrdata_d;
            done_q      <= done_d;
            done_bank_q <= done_bank_d;
            valid_out_q <= valid_out_d;
            out_bank_q  <= out_bank_d;
        end
    end

    assign wren      = wren_q;
    assign wraddress = wraddress_q;
    assign wrdata    = wrdata_q;
    assign valid_out = valid_out_q;
    assign out_bank  = out_bank_q;

endmodule
